// File: rtl/res_buffer.sv
// res_buffer: first-word-fall-through response FIFO with sticky overflow flag
// and a saturating count of responses dropped while full.
module res_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [7:0]       drop_count,
  input  logic             clr
);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic [7:0] drop_q, drop_d;
  logic push, pop, drop;
  assign empty      = count_q == '0;
  assign full       = count_q == FULL_CNT;
  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop        = !empty && out_ready;
    push       = in_valid && (!full || pop);
    drop       = in_valid && full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    overflow_d = clr ? drop : (overflow_q | drop);
    drop_d     = clr ? {7'd0, drop} : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= in_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end
endmodule

// File: tb/tb_res_buffer.sv
// tb_res_buffer: directed and random stimulus against a queue-based model
// of the response FIFO, with overflow/drop bookkeeping.
module tb_res_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] in_data = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic clr = 1'b0;
  logic [15:0] out_data;
  logic out_valid, full, empty, overflow;
  logic [3:0] count;
  logic [7:0] drop_count;
  int nvec = 0;
  int nerr = 0;
  logic [15:0] mq[$];
  logic m_ovf = 1'b0;
  int m_dc = 0;

  res_buffer #(.DEPTH(8), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .drop_count(drop_count), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".valid"}, 32'(out_valid), 32'(n != 0));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == 8));
    chk({tag, ".data"}, 32'(out_data), n != 0 ? 32'(mq[0]) : 32'd0);
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".dc"}, 32'(drop_count), 32'(m_dc));
  endtask

  // Called just after a rising edge; checks current outputs, applies one cycle.
  task automatic cyc(input string tag, input logic iv, input logic [15:0] d,
                     input logic rdy, input logic c);
    logic pop, push, drp;
    in_valid = iv; in_data = d; out_ready = rdy; clr = c;
    chk_model(tag);
    pop  = mq.size() != 0 && rdy;
    push = iv && (mq.size() < 8 || pop);
    drp  = iv && mq.size() == 8 && !pop;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(d);
    if (c) begin
      m_ovf = drp;
      m_dc = drp ? 1 : 0;
    end else if (drp) begin
      m_ovf = 1'b1;
      if (m_dc < 255) m_dc++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk_model("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    // single push, popped the cycle it appears
    cyc("p1", 1'b1, 16'h0011, 1'b1, 1'b0);
    chk("r31_head", 32'(out_data), 32'h0011);
    chk("r31_valid", 32'(out_valid), 32'd1);
    cyc("p1b", 1'b0, 16'h0, 1'b1, 1'b0);
    chk("r31_empty", 32'(empty), 32'd1);
    // overfill by two, then drain in order
    for (int i = 0; i < 10; i++) cyc("fill", 1'b1, 16'(i), 1'b0, 1'b0);
    chk("r32_full", 32'(full), 32'd1);
    chk("r32_ovf", 32'(overflow), 32'd1);
    chk("r32_dc", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk("r32_drain", 32'(out_data), 32'(i));
      cyc("drain", 1'b0, 16'h0, 1'b1, 1'b0);
    end
    chk("r32_empty", 32'(empty), 32'd1);
    cyc("clr0", 1'b0, 16'h0, 1'b0, 1'b1);
    // push into full FIFO while popping
    for (int i = 0; i < 8; i++) cyc("fill2", 1'b1, 16'h100 + 16'(i), 1'b0, 1'b0);
    cyc("pp_full", 1'b1, 16'hABCD, 1'b1, 1'b0);
    chk("r33_count", 32'(count), 32'd8);
    chk("r33_dc", 32'(drop_count), 32'd0);
    for (int i = 0; i < 7; i++) cyc("drain2", 1'b0, 16'h0, 1'b1, 1'b0);
    chk("r33_last", 32'(out_data), 32'hABCD);
    // saturation of the drop counter and clear behaviour
    for (int i = 0; i < 300; i++) cyc("sat", 1'b1, 16'($urandom), 1'b0, 1'b0);
    chk("r34_sat", 32'(drop_count), 32'd255);
    cyc("clr1", 1'b0, 16'h0, 1'b0, 1'b1);
    chk("r34_clr_ovf", 32'(overflow), 32'd0);
    chk("r34_clr_dc", 32'(drop_count), 32'd0);
    cyc("clrdrop", 1'b1, 16'h5555, 1'b0, 1'b1);
    chk("r34_cd_ovf", 32'(overflow), 32'd1);
    chk("r34_cd_dc", 32'(drop_count), 32'd1);
    for (int i = 0; i < 8; i++) cyc("drain3", 1'b0, 16'h0, 1'b1, 1'b0);
    cyc("clr2", 1'b0, 16'h0, 1'b0, 1'b1);
    // random traffic wrapping the pointers
    for (int i = 0; i < 200; i++)
      cyc("rand", 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0));
    // reset mid-burst
    while (mq.size() != 0) cyc("drain4", 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("pre", 1'b1, 16'h200 + 16'(i), 1'b0, 1'b0);
    chk("r36_cnt5", 32'(count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_dc = 0;
    chk_model("rst_async");
    in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    chk_model("rst_hold");
    rst = 1'b1;
    cyc("post", 1'b1, 16'h0017, 1'b0, 1'b0);
    chk("r36_head", 32'(out_data), 32'h0017);
    chk("r36_cnt", 32'(count), 32'd1);
    cyc("post2", 1'b0, 16'h0, 1'b1, 1'b0);
    chk_model("end");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
